// File: rtl/mlp_sequencer.sv
`default_nettype none
// =============================================================================
// mlp_sequencer : byte-stream loader, launch control and result capture for mlp
// Rev 1.0
// =============================================================================
module mlp_sequencer #(
   parameter int WORDSIZE = 8,
   parameter int IN_DIM   = 7,
   parameter int W_BYTES  = 19,
   parameter int TIMEOUT  = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WORDSIZE-1:0]          s_data,
   input  logic                         s_kind,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [IN_DIM*WORDSIZE-1:0]   data_in,
   output logic [63:0]                  data_weight_1_1,
   output logic [63:0]                  data_weight_1_2,
   output logic [23:0]                  data_weight_2_1,
   output logic                         start,
   input  logic [WORDSIZE-1:0]          mlp_data_out,
   input  logic                         mlp_done,
   output logic [WORDSIZE-1:0]          m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         weights_ok,
   output logic                         err,
   input  logic                         err_clr
);

   localparam int SP_W = $clog2(IN_DIM);
   localparam int WP_W = $clog2(W_BYTES);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t                       state_q;
   logic [SP_W-1:0]              sp_q;
   logic [WP_W-1:0]              wp_q;
   logic [7:0]                   tcnt_q;
   logic [IN_DIM*WORDSIZE-1:0]   din_q;
   logic [63:0]                  w11_q;
   logic [63:0]                  w12_q;
   logic [23:0]                  w21_q;
   logic                         start_q;
   logic [WORDSIZE-1:0]          mdata_q;
   logic                         mvalid_q;
   logic                         wok_q;
   logic                         err_q;
   logic                         accept;

   // Sample bytes are gated until a complete weight set is present.
   assign s_ready = (state_q == COLLECT) && (s_kind || wok_q);
   assign accept  = s_valid && s_ready;

   assign data_in         = din_q;
   assign data_weight_1_1 = w11_q;
   assign data_weight_1_2 = w12_q;
   assign data_weight_2_1 = w21_q;
   assign start           = start_q;
   assign m_data          = mdata_q;
   assign m_valid         = mvalid_q;
   assign weights_ok      = wok_q;
   assign err             = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= COLLECT;
         sp_q     <= '0;
         wp_q     <= '0;
         tcnt_q   <= '0;
         din_q    <= '0;
         w11_q    <= '0;
         w12_q    <= '0;
         w21_q    <= '0;
         start_q  <= 1'b0;
         mdata_q  <= '0;
         mvalid_q <= 1'b0;
         wok_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            COLLECT: begin
               if (accept && s_kind) begin
                  for (int i = 0; i < 8; i++) begin
                     if (wp_q == WP_W'(i))      w11_q[63-8*i -: 8] <= s_data;
                     if (wp_q == WP_W'(i + 8))  w12_q[63-8*i -: 8] <= s_data;
                  end
                  for (int i = 0; i < 3; i++) begin
                     if (wp_q == WP_W'(i + 16)) w21_q[23-8*i -: 8] <= s_data;
                  end
                  sp_q <= '0;
                  if (wp_q == WP_W'(W_BYTES - 1)) begin
                     wp_q  <= '0;
                     wok_q <= 1'b1;
                  end else begin
                     wp_q <= wp_q + 1'b1;
                     if (wp_q == '0) wok_q <= 1'b0;
                  end
               end else if (accept) begin
                  for (int i = 0; i < IN_DIM; i++) begin
                     if (sp_q == SP_W'(i)) din_q[IN_DIM*WORDSIZE-1-8*i -: 8] <= s_data;
                  end
                  if (sp_q == SP_W'(IN_DIM - 1)) begin
                     sp_q    <= '0;
                     tcnt_q  <= '0;
                     start_q <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     sp_q <= sp_q + 1'b1;
                  end
               end
            end
            RUN: begin
               // A done seen on the timeout cycle still delivers its result.
               if (mlp_done) begin
                  mdata_q  <= mlp_data_out;
                  mvalid_q <= 1'b1;
                  start_q  <= 1'b0;
                  state_q  <= HOLD;
               end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  start_q <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  mvalid_q <= 1'b0;
                  state_q  <= DRAIN;
               end
            end
            DRAIN: begin
               if (!mlp_done) state_q <= COLLECT;
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mlp_sequencer.sv
`default_nettype none
// Scoreboard bench for mlp_sequencer with a simple behavioural core model.
module tb_mlp_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_kind;
   logic        s_valid;
   logic        s_ready;
   logic [55:0] data_in;
   logic [63:0] data_weight_1_1;
   logic [63:0] data_weight_1_2;
   logic [23:0] data_weight_2_1;
   logic        start;
   logic [7:0]  mlp_data_out;
   logic        mlp_done;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        weights_ok;
   logic        err;
   logic        err_clr;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;

   int          core_lat   = 5;
   bit          core_hang  = 1'b0;
   int          done_extra = 0;
   logic [7:0]  core_result = 8'h00;

   always #5 clk = ~clk;

   mlp_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .s_data          (s_data),
      .s_kind          (s_kind),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .data_in         (data_in),
      .data_weight_1_1 (data_weight_1_1),
      .data_weight_1_2 (data_weight_1_2),
      .data_weight_2_1 (data_weight_2_1),
      .start           (start),
      .mlp_data_out    (mlp_data_out),
      .mlp_done        (mlp_done),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .weights_ok      (weights_ok),
      .err             (err),
      .err_clr         (err_clr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result monitor: every output handshake must match the next expected result.
   always @(negedge clk) begin
      if (rst && m_valid && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected: got %0h expected none", m_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (m_data !== mon_exp) begin
               errors++;
               $display("FAIL result: got %0h expected %0h", m_data, mon_exp);
            end
         end
      end
   end

   // Core model: done after core_lat cycles, held done_extra cycles past start falling.
   initial begin
      mlp_done     = 1'b0;
      mlp_data_out = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (start) begin
            for (int k = 0; k < core_lat; k++) begin @(posedge clk); #1; end
            if (!core_hang && start) begin
               mlp_data_out = core_result;
               mlp_done     = 1'b1;
               for (int k = 0; k < 20 && start; k++) begin @(posedge clk); #1; end
               for (int k = 0; k < done_extra; k++) begin @(posedge clk); #1; end
               mlp_done = 1'b0;
            end else begin
               for (int k = 0; k < 400 && start; k++) begin @(posedge clk); #1; end
            end
         end
      end
   end

   task automatic send_byte(input logic k, input logic [7:0] d);
      bit ok;
      ok      = 1'b0;
      s_kind  = k;
      s_data  = d;
      s_valid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_byte: got no handshake expected handshake for byte %0h", d);
      end
   endtask

   task automatic send_samples(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) send_byte(1'b0, 8'(base + 8'(i)));
   endtask

   task automatic wait_mvalid(input string name);
      int n;
      n = 0;
      while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
      check(name, {63'd0, m_valid}, 64'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; s_valid = 1'b0; s_kind = 1'b0; s_data = 8'h00;
      m_ready = 1'b1; err_clr = 1'b0;
      #3 rst = 1'b0;
      #10;
      check("rst_s_ready",  {63'd0, s_ready},    64'd0);
      check("rst_start",    {63'd0, start},      64'd0);
      check("rst_m_valid",  {63'd0, m_valid},    64'd0);
      check("rst_m_data",   {56'd0, m_data},     64'd0);
      check("rst_data_in",  {8'd0, data_in},     64'd0);
      check("rst_w11",      data_weight_1_1,     64'd0);
      check("rst_w12",      data_weight_1_2,     64'd0);
      check("rst_w21",      {40'd0, data_weight_2_1}, 64'd0);
      check("rst_wok",      {63'd0, weights_ok}, 64'd0);
      check("rst_err",      {63'd0, err},        64'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Sample byte refused without weights
      s_kind = 1'b0; s_valid = 1'b1; #1;
      check("gate_s_ready", {63'd0, s_ready}, 64'd0);
      s_valid = 1'b0;
      @(posedge clk); #1;

      // Load and infer with output backpressure
      for (int i = 1; i <= 19; i++) send_byte(1'b1, 8'(i));
      check("load_wok", {63'd0, weights_ok}, 64'd1);
      check("load_w11", data_weight_1_1, 64'h0102030405060708);
      check("load_w12", data_weight_1_2, 64'h090A0B0C0D0E0F10);
      check("load_w21", {40'd0, data_weight_2_1}, 64'h111213);
      m_ready = 1'b0; core_result = 8'h5A; core_lat = 5; done_extra = 0;
      exp_q.push_back(8'h5A);
      send_samples(8'h10, 7);
      check("launch_start",   {63'd0, start}, 64'd1);
      check("launch_data_in", {8'd0, data_in}, 64'h10111213141516);
      check("launch_s_ready", {63'd0, s_ready}, 64'd0);
      wait_mvalid("infer_m_valid");
      check("infer_m_data", {56'd0, m_data}, 64'h5A);
      check("infer_start",  {63'd0, start}, 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_m_valid", {63'd0, m_valid}, 64'd1);
         check("bp_m_data",  {56'd0, m_data}, 64'h5A);
         check("bp_s_ready", {63'd0, s_ready}, 64'd0);
      end
      m_ready = 1'b1; s_kind = 1'b0;
      @(posedge clk); #1;
      check("bp_release_m_valid", {63'd0, m_valid}, 64'd0);
      @(posedge clk); #1;
      check("bp_release_s_ready", {63'd0, s_ready}, 64'd1);

      // Sticky done: stay in DRAIN while the core holds done
      done_extra = 4; core_result = 8'hC3;
      exp_q.push_back(8'hC3);
      send_samples(8'h20, 7);
      wait_mvalid("sticky_m_valid");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("sticky_start",   {63'd0, start}, 64'd0);
         check("sticky_s_ready", {63'd0, s_ready}, 64'd0);
      end
      n = 0;
      while (!s_ready && n < 10) begin @(posedge clk); #1; n++; end
      check("sticky_return", {63'd0, s_ready}, 64'd1);
      done_extra = 0;

      // Watchdog timeout
      core_hang = 1'b1;
      send_samples(8'h30, 7);
      n = 0;
      while (start && n < 300) begin n++; @(posedge clk); #1; end
      check("timeout_cycles", 64'(n), 64'd255);
      check("timeout_err",    {63'd0, err}, 64'd1);
      check("timeout_m_valid", {63'd0, m_valid}, 64'd0);
      core_hang = 1'b0;
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      check("err_clr", {63'd0, err}, 64'd0);
      core_result = 8'h3C;
      exp_q.push_back(8'h3C);
      send_samples(8'h38, 7);
      wait_mvalid("post_timeout_m_valid");
      @(posedge clk); #1;

      // Partial sample discarded by a weight byte; reload restarts weights
      send_samples(8'h40, 3);
      send_byte(1'b1, 8'hA0);
      check("discard_wok", {63'd0, weights_ok}, 64'd0);
      for (int i = 1; i < 19; i++) send_byte(1'b1, 8'(8'hA0 + 8'(i)));
      check("reload_wok", {63'd0, weights_ok}, 64'd1);
      check("reload_w11", data_weight_1_1, 64'hA0A1A2A3A4A5A6A7);
      check("reload_w12", data_weight_1_2, 64'hA8A9AAABACADAEAF);
      check("reload_w21", {40'd0, data_weight_2_1}, 64'hB0B1B2);
      core_result = 8'h77;
      exp_q.push_back(8'h77);
      send_samples(8'h50, 4);
      check("sp_reset_start", {63'd0, start}, 64'd0);
      send_samples(8'h54, 3);
      check("sp_reset_launch", {63'd0, start}, 64'd1);
      check("sp_reset_data_in", {8'd0, data_in}, 64'h50515253545556);
      wait_mvalid("sp_reset_m_valid");
      @(posedge clk); #1;

      // Asynchronous reset during RUN
      core_hang = 1'b1;
      send_samples(8'h60, 7);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("areset_start",   {63'd0, start}, 64'd0);
      check("areset_m_valid", {63'd0, m_valid}, 64'd0);
      check("areset_wok",     {63'd0, weights_ok}, 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      core_hang = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/mlp_sequencer.md
# mlp_sequencer

Byte-stream front end and result collector for the `mlp` core: a single block that sits both directly upstream and directly downstream of it. Weight/bias bytes and sample bytes arrive on one valid/ready byte stream and are assembled into the core's parallel weight and data buses. The block then drives the core's `start`, waits for its `done`, and returns the 8-bit result on a valid/ready output stream. A watchdog flags a core that never completes.

## Interface
- `WORDSIZE`, 8, byte width; fixed at 8 for this core.
- `IN_DIM`, 7, sample bytes per inference.
- `W_BYTES`, 19, weight/bias bytes per full load (8 + 8 + 3).
- `TIMEOUT`, 255, maximum cycles in RUN before abort; 8-bit counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  input byte.
- `s_kind`  in  1  0 = sample byte, 1 = weight byte; qualified by `s_valid`.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  input byte accepted when `s_valid & s_ready`.
- `data_in`  out  56  sample to core.
- `data_weight_1_1`  out  64  hidden neuron 1 weights[63:8], bias[7:0].
- `data_weight_1_2`  out  64  hidden neuron 2 weights[63:8], bias[7:0].
- `data_weight_2_1`  out  24  output neuron weights[23:8], bias[7:0].
- `start`  out  1  core start, registered.
- `mlp_data_out`  in  8  core result.
- `mlp_done`  in  1  core done.
- `m_data`  out  8  captured result.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed when `m_valid & m_ready`.
- `weights_ok`  out  1  a full weight load is present.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  synchronous clear of `err`.

## Operation
- States: COLLECT, RUN, HOLD, DRAIN. The reset state is COLLECT.
- `s_ready` equals `(state == COLLECT) & (s_kind | weights_ok)`.
- **Weight byte accepted.** The byte is written at weight pointer `wp` (0..18), and `wp` increments. The bus is filled MSB-first:
  - `wp` 0..7 fill `data_weight_1_1[63:56]` down to `[7:0]`.
  - `wp` 8..15 fill `data_weight_1_2` in the same order.
  - `wp` 16..18 fill `data_weight_2_1[23:16]`, `[15:8]`, `[7:0]`.
- **Weight pointer effects.**
  - `wp == 0` on accept: `weights_ok` clears.
  - `wp == 18` on accept: `wp` wraps to 0 and `weights_ok` sets.
  - Any accepted weight byte resets the sample pointer `sp` to 0, discarding a partial sample.
- **Sample byte accepted.** The byte is written to `data_in[55-8*sp -: 8]`, and `sp` increments.
  - On the byte with `sp == IN_DIM-1`: `sp` goes to 0, the next state is RUN, and `start` goes to 1.
- **RUN.** `start` is held at 1, and `data_in` and all weight buses are held stable.
  - While `mlp_done == 0`, the watchdog `tcnt` increments.
  - On the first cycle with `mlp_done == 1`: `m_data` captures `mlp_data_out`, `m_valid` goes to 1, `start` goes to 0, and the next state is HOLD.
  - If `tcnt == TIMEOUT-1` and `mlp_done == 0`: `err` sets, `start` goes to 0, and the next state is DRAIN with no result.
  - If done and timeout occur in the same cycle, done wins.
- **HOLD.** `m_data` and `m_valid` are held. On `m_valid & m_ready`: `m_valid` goes to 0 and the next state is DRAIN.
- **DRAIN.** `start` is 0. The block returns to COLLECT on the first cycle with `mlp_done == 0`, which may be the same cycle it is entered. This guarantees the core has released `done` before the next launch.
- **Error flag.**
  - `err` stays set until reset or `err_clr`.
  - If `err_clr` and a new timeout coincide, the set wins.
  - `err` does not block operation.
- Bytes arriving while `s_ready == 0` are not consumed; the upstream holds them.

## Timing
- **Reset values.** All outputs 0 (`s_ready`, `start`, `m_valid`, `m_data`, all buses, `weights_ok`, `err`). Internal state: `wp = 0`, `sp = 0`, `tcnt = 0`, state COLLECT.
  - Reset asserted mid-RUN or mid-HOLD drops `start`/`m_valid` immediately (asynchronous) and loses the weights; a reload is required.
- **Launch latency.** The 7th sample handshake at edge N gives `start = 1` after edge N. `s_ready` is 0 from edge N.
- **Capture latency.** `mlp_done` sampled high at edge M gives `m_valid = 1` and `start = 0` after edge M.
- **Minimum turnaround.** With `mlp_done` already low in DRAIN, the block is back in COLLECT one cycle after the `m_ready` handshake. Next-sample throughput is `IN_DIM + core latency + 3` cycles.
- **Timeout.** `start` falls after the edge on which the TIMEOUT-th consecutive RUN cycle without done is sampled. `tcnt` clears on entering RUN.
- **Outputs in COLLECT.** The weight buses change only in COLLECT, one byte per handshake. `data_in` bytes update as received; the core ignores them while `start == 0`.

## Test plan
- **Load and infer.** Reset, then 19 weight bytes 0x01..0x13 → `weights_ok = 1`, `data_weight_1_1 = 0x0102030405060708`, `data_weight_2_1 = 0x111213`. Then 7 sample bytes 0x10..0x16 → `data_in = 0x10111213141516` and `start = 1` the next cycle. Core model asserts done after 5 cycles with result 0x5A → `m_data = 0x5A`, `m_valid = 1`.
- **Output backpressure.** Hold `m_ready = 0` for 10 cycles → `m_valid` and `m_data` stable, `s_ready = 0`. Raise `m_ready` → `m_valid` low next cycle, and `s_ready = 1` once `mlp_done` is low.
- **Sticky done.** Core holds done high for 4 extra cycles after `start` drops → block stays in DRAIN, no second launch, no second `m_valid`.
- **Timeout.** Core never asserts done → `start` low and `err = 1` after 255 RUN cycles, no `m_valid`. Pulse `err_clr` → `err = 0`. A following inference completes normally.
- **Weight gate and partial-sample discard.** Sample byte with `weights_ok = 0` → `s_ready = 0`. Send 3 sample bytes, then 1 weight byte → `sp = 0` and `weights_ok = 0`.
- **Async reset mid-run.** Assert `rst` low during RUN → `start`, `m_valid` and `weights_ok` go to 0 without waiting for a clock edge.
